// File: rtl/boolfn_tt_engine.sv
// Truth-table Boolean function engine: single-vector evaluation and streamed sweep.
// Define BOOLFN_ONESCNT_EN to build the ones_cnt counter; otherwise ones_cnt is tied to 0.
module boolfn_tt_engine #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tt_we,
  input  logic [N_IN-1:0] tt_addr,
  input  logic            tt_din,
  input  logic            ev_valid,
  input  logic [N_IN-1:0] ev_x,
  output logic            ev_ready,
  output logic            ev_out_valid,
  output logic            ev_f,
  input  logic            sw_start,
  input  logic            sw_ready,
  output logic            sw_valid,
  output logic [N_IN-1:0] sw_x,
  output logic            sw_f,
  output logic            sw_last,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt
);

  localparam int D = 1 << N_IN;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [D-1:0]    tt;
  logic [1:0]      state;
  logic [N_IN-1:0] nxt;

  assign busy     = (state == LOAD) || (state == STREAM);
  assign ev_ready = !busy;
  assign nxt      = sw_x + N_IN'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tt           <= '0;
      state        <= IDLE;
      ev_out_valid <= 1'b0;
      ev_f         <= 1'b0;
      sw_valid     <= 1'b0;
      sw_x         <= '0;
      sw_f         <= 1'b0;
      sw_last      <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Evaluation reads the table before any same-edge write lands
      if (tt_we && !busy) tt[tt_addr] <= tt_din;
      ev_out_valid <= ev_valid && !busy;
      if (ev_valid && !busy) ev_f <= tt[ev_x];
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sw_start) begin
            sw_x  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          sw_valid <= 1'b1;
          sw_x     <= '0;
          sw_f     <= tt[0];
          sw_last  <= 1'(D == 1);
          state    <= STREAM;
        end
        STREAM: begin
          if (sw_valid && sw_ready) begin
            if (sw_last) begin
              sw_valid <= 1'b0;
              sw_last  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              sw_x    <= nxt;
              sw_f    <= tt[nxt];
              sw_last <= &nxt;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOLFN_ONESCNT_EN
  logic [N_IN:0] ones_q;
  logic          beat_acc;

  assign beat_acc = (state == STREAM) && sw_valid && sw_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else if (state == IDLE && sw_start) begin
      ones_q <= '0;
    end else if (beat_acc && sw_f) begin
      ones_q <= ones_q + (N_IN+1)'(1);
    end
  end

  assign ones_cnt = ones_q;
`else
  assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_boolfn_tt_engine.sv
// Directed testbench for boolfn_tt_engine: evaluation vectors, sweeps, stalls,
// same-edge write/evaluate and reset during a sweep.
module tb_boolfn_tt_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tt_we = 1'b0;
  logic [3:0] tt_addr = '0;
  logic       tt_din = 1'b0;
  logic       ev_valid = 1'b0;
  logic [3:0] ev_x = '0;
  logic       ev_ready;
  logic       ev_out_valid;
  logic       ev_f;
  logic       sw_start = 1'b0;
  logic       sw_ready = 1'b1;
  logic       sw_valid;
  logic [3:0] sw_x;
  logic       sw_f;
  logic       sw_last;
  logic       busy;
  logic       done;
  logic [4:0] ones_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] TT_EXP = 16'hF272;

  typedef struct {
    logic [3:0] x;
    logic       f;
  } vec_t;

  vec_t vecs [9];

  boolfn_tt_engine #(.N_IN(4)) dut (
    .clk(clk), .rst(rst),
    .tt_we(tt_we), .tt_addr(tt_addr), .tt_din(tt_din),
    .ev_valid(ev_valid), .ev_x(ev_x), .ev_ready(ev_ready),
    .ev_out_valid(ev_out_valid), .ev_f(ev_f),
    .sw_start(sw_start), .sw_ready(sw_ready), .sw_valid(sw_valid),
    .sw_x(sw_x), .sw_f(sw_f), .sw_last(sw_last),
    .busy(busy), .done(done), .ones_cnt(ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_ones(input int n);
`ifdef BOOLFN_ONESCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic eval_all(input logic [15:0] t, input string name);
    for (int i = 0; i < 16; i++) begin
      ev_valid = 1'b1;
      ev_x = 4'(i);
      step;
      chk({name, "_vld"}, int'(ev_out_valid), 1);
      chk({name, "_f"}, int'(ev_f), int'(t[i]));
    end
    ev_valid = 1'b0;
    step;
    chk({name, "_vld_end"}, int'(ev_out_valid), 0);
  endtask

  task automatic run_sweep(input bit stall, input bit poke);
    int cyc = 0;
    int k = 0;
    int stalls = 0;
    int ones = 0;
    int done_cyc = -1;
    bit rdy;
    sw_ready = 1'b1;
    sw_start = 1'b1;
    step;
    sw_start = 1'b0;
    chk("sw_busy_start", int'(busy), 1);
    chk("sw_valid_start", int'(sw_valid), 0);
    while (done_cyc < 0 && cyc < 100) begin
      ev_valid = 1'b0;
      tt_we = 1'b0;
      if (sw_valid) begin
        chk("sw_x", int'(sw_x), k);
        chk("sw_f", int'(sw_f), int'(TT_EXP[k[3:0]]));
        chk("sw_last", int'(sw_last), int'(k == 15));
      end
      rdy = stall ? (cyc % 2 == 0) : 1'b1;
      sw_ready = rdy;
      if (sw_valid && !rdy) stalls++;
      if (sw_valid && rdy) begin
        if (TT_EXP[k[3:0]]) ones++;
        k++;
      end
      if (poke && cyc == 5) begin
        ev_valid = 1'b1;
        ev_x = 4'd3;
        tt_we = 1'b1;
        tt_addr = 4'd0;
        tt_din = 1'b1;
      end
      step;
      cyc++;
      if (busy) begin
        chk("ev_ready_busy", int'(ev_ready), 0);
        chk("ev_out_busy", int'(ev_out_valid), 0);
      end
      if (done) done_cyc = cyc;
    end
    ev_valid = 1'b0;
    tt_we = 1'b0;
    sw_ready = 1'b1;
    chk("sw_done_cycle", done_cyc, 17 + stalls);
    chk("sw_beats", k, 16);
    chk("sw_busy_done", int'(busy), 0);
    chk("sw_valid_done", int'(sw_valid), 0);
    chk("sw_ones", int'(ones_cnt), exp_ones(ones));
    step;
    chk("sw_done_pulse", int'(done), 0);
    chk("sw_ones_hold", int'(ones_cnt), exp_ones(9));
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0] = '{4'd0, 1'b0};
    vecs[1] = '{4'd1, 1'b1};
    vecs[2] = '{4'd4, 1'b1};
    vecs[3] = '{4'd13, 1'b1};
    vecs[4] = '{4'd10, 1'b0};
    vecs[5] = '{4'd2, 1'b0};
    vecs[6] = '{4'd7, 1'b0};
    vecs[7] = '{4'd9, 1'b1};
    vecs[8] = '{4'd15, 1'b1};

    step;
    step;
    chk("rst_ev_ready", int'(ev_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sw_valid", int'(sw_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ev_out", int'(ev_out_valid), 0);
    chk("rst_ones", int'(ones_cnt), 0);
    rst = 1'b0;
    step;

    eval_all(16'h0000, "ev_zero");

    for (int i = 0; i < 16; i++) begin
      tt_we = 1'b1;
      tt_addr = 4'(i);
      tt_din = TT_EXP[i];
      step;
    end
    tt_we = 1'b0;

    for (int i = 0; i < 9; i++) begin
      ev_valid = 1'b1;
      ev_x = vecs[i].x;
      step;
      chk("vec_vld", int'(ev_out_valid), 1);
      chk("vec_f", int'(ev_f), int'(vecs[i].f));
    end
    ev_valid = 1'b0;
    step;

    run_sweep(1'b0, 1'b0);
    step;
    run_sweep(1'b1, 1'b1);
    eval_all(TT_EXP, "tt_after_sweep");

    tt_we = 1'b1;
    tt_addr = 4'd3;
    tt_din = 1'b1;
    ev_valid = 1'b1;
    ev_x = 4'd3;
    step;
    tt_we = 1'b0;
    chk("rbw_old_vld", int'(ev_out_valid), 1);
    chk("rbw_old_f", int'(ev_f), 0);
    step;
    chk("rbw_new_f", int'(ev_f), 1);
    ev_valid = 1'b0;
    step;

    sw_ready = 1'b1;
    sw_start = 1'b1;
    step;
    sw_start = 1'b0;
    n = 0;
    while (!(sw_valid && sw_x == 4'd7) && n < 40) begin
      step;
      n++;
    end
    chk("rst_mid_reach7", int'(sw_valid && sw_x == 4'd7), 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(sw_valid), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_ones", int'(ones_cnt), 0);
    chk("rst_mid_ready", int'(ev_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (done || busy) seen = 1'b1;
    end
    chk("rst_mid_no_done", int'(seen), 0);
    eval_all(16'h0000, "rst_mid_tt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
